// File: rtl/display_arb_pkg.sv
// Shared types and helpers for the display slot arbiter.
//
// Contents:
//   NREQ     - number of requesters (matches the 3-to-8 digit-select decoder)
//   IDXW     - width of a requester index
//   arb_state_e - arbiter FSM state encoding
//   rr_pick  - round-robin search starting at a given pointer
package display_arb_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned IDXW = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Returns the first index at or after ptr (wrapping modulo NREQ) whose request bit is set.
    // If no bit is set the result is ptr; callers only use it when req is non-zero.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] idx;
        logic            found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            // 3-bit addition wraps naturally, giving the modulo-8 search order.
            idx = ptr + IDXW'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Slow tick prescaler for the display slot arbiter.
//
// Divides the 100 Hz system clock by PRESCALE; tick is high for one cycle every PRESCALE cycles.
//
// Ports:
//   hz100 - system clock
//   reset - asynchronous, active-high reset (clears the count)
//   tick  - one-cycle strobe, high while the count sits at PRESCALE-1
module tick_gen #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic hz100,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    // With PRESCALE=1 the count stays at 0 == LAST, so tick is high every cycle.
    assign tick = (count_q == LAST);

endmodule

// File: rtl/display_slot_arbiter.sv
// Round-robin arbiter sharing the digit-select decoder among NREQ requesters.
//
// A grant is held until its requester drops its line or until HOLD_TICKS slow ticks have been
// counted, whichever comes first. Every release passes through at least one IDLE cycle.
//
// Ports:
//   hz100   - system clock
//   reset   - asynchronous, active-high reset
//   req     - level-sensitive request lines, one per requester
//   grant   - one-hot grant, all-zero while idle
//   sel     - index of the current or most recent grant (decoder select)
//   active  - high while a grant is held
//   expired - one-cycle pulse on the first idle cycle after a timeout release
module display_slot_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned PRESCALE   = 10,
    parameter int unsigned HOLD_TICKS = 5
) (
    input  logic            hz100,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] sel,
    output logic            active,
    output logic            expired
);

    localparam int unsigned HW = $clog2(HOLD_TICKS) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ - 1) {1'b0}}, 1'b1};

    arb_state_e      state_q;
    logic [IDXW-1:0] ptr_q;
    logic [HW-1:0]   hold_q;
    logic            tick;
    logic [IDXW-1:0] winner;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .hz100(hz100),
        .reset(reset),
        .tick (tick)
    );

    assign winner = rr_pick(req, ptr_q);

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant   <= '0;
            sel     <= '0;
            active  <= 1'b0;
            expired <= 1'b0;
        end else begin
            // expired is a pulse: cleared unless a timeout fires this cycle.
            expired <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        sel     <= winner;
                        grant   <= ONE << winner;
                        active  <= 1'b1;
                        hold_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req[sel]) begin
                        // Early release by the owner.
                        grant   <= '0;
                        active  <= 1'b0;
                        ptr_q   <= sel + 1'b1;
                        state_q <= IDLE;
                    end else if (tick && (hold_q == HOLD_LAST)) begin
                        // Forced release after the hold budget is spent.
                        grant   <= '0;
                        active  <= 1'b0;
                        ptr_q   <= sel + 1'b1;
                        expired <= 1'b1;
                        state_q <= IDLE;
                    end else if (tick) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant   <= '0;
                    active  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_slot_arbiter.sv
// Directed self-checking bench for display_slot_arbiter.
// dut uses PRESCALE=4, HOLD_TICKS=2; dut1 uses PRESCALE=1, HOLD_TICKS=1.
module tb_display_slot_arbiter;

    logic       hz100;
    logic       reset;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       active;
    logic       expired;

    logic       reset1;
    logic [7:0] req1;
    logic [7:0] grant1;
    logic [2:0] sel1;
    logic       active1;
    logic       expired1;

    int tests;
    int fails;

    display_slot_arbiter #(
        .PRESCALE  (4),
        .HOLD_TICKS(2)
    ) dut (
        .hz100  (hz100),
        .reset  (reset),
        .req    (req),
        .grant  (grant),
        .sel    (sel),
        .active (active),
        .expired(expired)
    );

    display_slot_arbiter #(
        .PRESCALE  (1),
        .HOLD_TICKS(1)
    ) dut1 (
        .hz100  (hz100),
        .reset  (reset1),
        .req    (req1),
        .grant  (grant1),
        .sel    (sel1),
        .active (active1),
        .expired(expired1)
    );

    initial hz100 = 1'b0;
    always #5 hz100 = ~hz100;

    task automatic step();
        @(posedge hz100);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks grant/active/expired of the PRESCALE=4 instance.
    task automatic check_main(input string tag, input logic [7:0] g, input logic a,
                              input logic e);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".active"}, 32'(active), 32'(a));
        check({tag, ".expired"}, 32'(expired), 32'(e));
    endtask

    initial begin
        logic [7:0] exp_g;
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        req    = 8'h00;
        reset1 = 1'b1;
        req1   = 8'h00;

        // Reset state.
        step();
        check_main("reset", 8'h00, 1'b0, 1'b0);
        check("reset.sel", 32'(sel), 32'd0);

        // Lone requester 3: grant after one cycle, timeout on the 2nd tick, one idle cycle,
        // then re-granted. Ticks land on edges 4 and 8 after reset release.
        req   = 8'h08;
        reset = 1'b0;
        step();
        check_main("single.e1", 8'h08, 1'b1, 1'b0);
        check("single.sel", 32'(sel), 32'd3);
        repeat (6) step();
        check_main("single.e7", 8'h08, 1'b1, 1'b0);
        step();
        check_main("single.e8", 8'h00, 1'b0, 1'b1);
        check("single.sel_hold", 32'(sel), 32'd3);
        step();
        check_main("single.e9", 8'h08, 1'b1, 1'b0);

        // All requesting: each grant lasts 7 cycles, then one idle cycle with expired.
        reset = 1'b1;
        req   = 8'h00;
        step();
        req   = 8'hFF;
        reset = 1'b0;
        for (int n = 1; n <= 65; n++) begin
            step();
            if (((n - 1) % 8) == 7) begin
                check_main("rr.idle", 8'h00, 1'b0, 1'b1);
            end else begin
                exp_g = 8'h01 << (((n - 1) / 8) % 8);
                check_main("rr.busy", exp_g, 1'b1, 1'b0);
            end
            check("rr.onehot0", 32'($onehot0(grant)), 32'd1);
        end

        // Early release of requester 5, then pointer sits at 6 and wraps to 0.
        reset = 1'b1;
        req   = 8'h00;
        step();
        req   = 8'h20;
        reset = 1'b0;
        step();
        check_main("early.grant", 8'h20, 1'b1, 1'b0);
        req = 8'h00;
        step();
        check_main("early.release", 8'h00, 1'b0, 1'b0);
        check("early.sel_hold", 32'(sel), 32'd5);
        req = 8'h21;
        step();
        check_main("early.next", 8'h01, 1'b1, 1'b0);
        check("early.next_sel", 32'(sel), 32'd0);

        // Wrap: early-release index 6 to park ptr at 7, then 7 wins, then 0 after timeout.
        reset = 1'b1;
        req   = 8'h00;
        step();
        req   = 8'h40;
        reset = 1'b0;
        step();
        check_main("wrap.g6", 8'h40, 1'b1, 1'b0);
        req = 8'h81;
        step();
        check_main("wrap.rel6", 8'h00, 1'b0, 1'b0);
        step();
        check_main("wrap.g7", 8'h80, 1'b1, 1'b0);
        check("wrap.sel7", 32'(sel), 32'd7);
        repeat (4) step();
        check_main("wrap.g7_e7", 8'h80, 1'b1, 1'b0);
        step();
        check_main("wrap.timeout", 8'h00, 1'b0, 1'b1);
        step();
        check_main("wrap.g0", 8'h01, 1'b1, 1'b0);
        check("wrap.sel0", 32'(sel), 32'd0);

        // Reset asserted between edges drops outputs immediately.
        reset = 1'b1;
        req   = 8'h00;
        step();
        req   = 8'h10;
        reset = 1'b0;
        step();
        check_main("mid.grant", 8'h10, 1'b1, 1'b0);
        check("mid.sel", 32'(sel), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_main("mid.async", 8'h00, 1'b0, 1'b0);
        check("mid.async_sel", 32'(sel), 32'd0);
        step();
        req   = 8'h06;
        reset = 1'b0;
        step();
        check_main("mid.restart", 8'h02, 1'b1, 1'b0);
        check("mid.restart_sel", 32'(sel), 32'd1);

        // PRESCALE=1, HOLD_TICKS=1: grant and idle alternate with period 2.
        req1   = 8'h01;
        reset1 = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            if ((n % 2) == 1) begin
                check("fast.grant", 32'(grant1), 32'h01);
                check("fast.active", 32'(active1), 32'd1);
                check("fast.expired", 32'(expired1), 32'd0);
            end else begin
                check("fast.idle_grant", 32'(grant1), 32'h00);
                check("fast.idle_active", 32'(active1), 32'd0);
                check("fast.idle_expired", 32'(expired1), 32'd1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/display_slot_arbiter.md
Name: display_slot_arbiter

Overview:
- Round-robin arbiter that shares the single 3-to-8 digit-select decoder, and through it the eight seven-segment decimal-point lanes, among 8 requesters.
- Each grant is held for a bounded number of slow ticks derived from the 100 Hz system clock.
- The winning requester's index drives the decoder select.
- Sits between pushbuttons or other requesters and the decoder instance in top.

Parameters:
- NREQ, 8: number of requesters; fixed to the decoder width; index width is 3.
- PRESCALE, 10: hz100 cycles per tick (10 = 10 Hz tick); must be >= 1.
- HOLD_TICKS, 5: maximum ticks a grant is held before forced release; must be >= 1.

Ports:
- hz100  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  8  request lines, level-sensitive, one bit per requester.
- grant  out  8  one-hot grant; all-zero when idle.
- sel  out  3  binary index of the current or most recent grant; feeds the decoder input.
- active  out  1  high while a grant is held.
- expired  out  1  one-cycle pulse when a grant is force-released by timeout.

Behaviour:
- One clock, hz100. Reset is asynchronous and active-high; all state is cleared on reset assertion, independent of the clock.
- Reset values: grant=0, sel=0, active=0, expired=0, rr pointer ptr=0, prescaler count=0, hold count=0, state=IDLE.
- Prescaler:
  - Free-running counter 0..PRESCALE-1.
  - tick is high for one cycle when count==PRESCALE-1; count then wraps to 0.
  - Runs in every state.
  - PRESCALE=1 gives tick every cycle.
- State IDLE:
  - grant=0, active=0.
  - If req!=0, search indices ptr, ptr+1, ... ptr+7 (mod 8) and pick the first with req set.
  - Next edge: sel=winner, grant=1<<winner, active=1, hold=0, state=BUSY.
  - Latency is exactly 1 cycle from sampled req to grant.
- State BUSY, priority order evaluated each cycle:
  - (a) req[sel]==0 (early release): next edge grant=0, active=0, ptr=(sel+1) mod 8, state=IDLE; expired stays 0.
  - (b) else, if tick and hold==HOLD_TICKS-1 (timeout): same release as (a), plus expired=1 for exactly one cycle, coincident with the first IDLE cycle.
  - (c) else, if tick: hold=hold+1.
  - (d) else: no change.
- Timing details:
  - A tick in the same cycle the grant first appears counts; the hold time is therefore between HOLD_TICKS-1 and HOLD_TICKS tick periods.
  - Every release passes through at least one IDLE cycle. There is never a back-to-back grant, and grant is never multi-hot.
- sel retains the last granted index while IDLE. It changes only on a new grant or on reset.
- Requests from other requesters while BUSY do not preempt; they are considered at the next IDLE arbitration.
- Wrap-around: the pointer and the search wrap modulo 8, so 7+1 -> 0.
- A lone requester held high is re-granted after its one-cycle IDLE gap.
- Reset mid-grant: outputs drop immediately, asynchronously. After deassertion, arbitration restarts from ptr=0.
- Width rules: hold counter is clog2(HOLD_TICKS)+1 bits; prescaler counter is clog2(PRESCALE)+1 bits; no overflow is reachable.

Decomposition:
- Package display_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - localparam NREQ=8;
  - localparam IDXW=3.
- Sub-module tick_gen(hz100, reset, tick) with parameter PRESCALE is the prescaler.
- The round-robin search is a function in the package or local to the arbiter; no further sub-modules.

Test Plan (PRESCALE=4, HOLD_TICKS=2 unless noted):
- Reset then req=8'h08 held -> one cycle later grant=8'h08, sel=3, active=1. expired pulses one cycle after the 2nd tick in BUSY. Then 1 IDLE cycle, then grant=8'h08 again.
- req=8'hFF held -> grant order 01,02,04,...,80,01. Each grant ends by expired, each separated by one IDLE cycle, and grant is never multi-hot.
- Early release: req=8'h20, drop req[5] 1 cycle after grant -> next edge grant=0, expired=0, then ptr=6. With req=8'h21 next, grant=8'h01.
- Wrap: drive grant to index 7 (ptr=7), then req=8'h81 -> grant=8'h80, then after release grant=8'h01.
- Reset asserted mid-grant, between clock edges -> grant=0, active=0, sel=0 immediately. After release, req=8'h06 -> grant=8'h02.
- PRESCALE=1, HOLD_TICKS=1, req=8'h01 held -> grant lasts exactly 1 cycle, expired coincides with the IDLE cycle, and the grant/idle pattern repeats with period 2.
